// File: rtl/core_seq.sv
// core_seq: sequences one conv tile through weight load, activation execute, psum drain and accumulate.
// Every inst field is registered and reflects the state occupied during the previous cycle.
module core_seq #(
   parameter int row      = 8,
   parameter int col      = 8,
   parameter int KIJ      = 9,
   parameter int LEN_NIJ  = 36,
   parameter int LEN_ONIJ = 16,
   parameter int W_BASE   = 0,
   parameter int A_BASE   = 1024,
   parameter int P_BASE   = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        ofifo_valid,
   output logic [34:0] inst,
   output logic        busy,
   output logic        out_valid,
   output logic        done
);
   typedef enum logic [3:0] {IDLE, W_L0, W_LOAD, W_WAIT, A_L0, EXEC, E_WAIT, DRAIN, ACC, FIN} state_t;
   localparam logic [34:0] IDLE_INST = 35'h1_800C_0000;
   state_t      state;
   logic [31:0] cnt;
   logic [31:0] kij;
   logic [31:0] o;
   logic [31:0] k;
   logic        relu_d;
   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         cnt       <= '0;
         kij       <= '0;
         o         <= '0;
         k         <= '0;
         inst      <= IDLE_INST;
         busy      <= 1'b0;
         out_valid <= 1'b0;
         done      <= 1'b0;
         relu_d    <= 1'b0;
      end else begin
         inst      <= IDLE_INST;
         done      <= 1'b0;
         relu_d    <= inst[34];
         out_valid <= relu_d;
         case (state)
            IDLE: if (start) begin
               state <= W_L0;
               cnt   <= '0;
               kij   <= '0;
               o     <= '0;
               k     <= '0;
               busy  <= 1'b1;
            end
            W_L0: begin
               // l0 write trails the xmem read by one cycle to cover SRAM read latency
               inst[19]   <= cnt >= col;
               inst[17:7] <= cnt < col ? 11'(W_BASE + kij * col + cnt) : 11'd0;
               inst[2]    <= cnt != 0;
               if (cnt == col) begin
                  state <= W_LOAD;
                  cnt   <= '0;
               end else cnt <= cnt + 1;
            end
            W_LOAD: begin
               inst[3] <= 1'b1;
               inst[0] <= 1'b1;
               if (cnt == col - 1) begin
                  state <= W_WAIT;
                  cnt   <= '0;
               end else cnt <= cnt + 1;
            end
            W_WAIT: if (cnt == row + col - 1) begin
               state <= A_L0;
               cnt   <= '0;
            end else cnt <= cnt + 1;
            A_L0: begin
               inst[19]   <= cnt >= LEN_NIJ;
               inst[17:7] <= cnt < LEN_NIJ ? 11'(A_BASE + cnt) : 11'd0;
               inst[2]    <= cnt != 0;
               if (cnt == LEN_NIJ) begin
                  state <= EXEC;
                  cnt   <= '0;
               end else cnt <= cnt + 1;
            end
            EXEC: begin
               inst[3] <= 1'b1;
               inst[1] <= 1'b1;
               if (cnt == LEN_NIJ - 1) begin
                  state <= E_WAIT;
                  cnt   <= '0;
               end else cnt <= cnt + 1;
            end
            E_WAIT: if (cnt == row + col - 1) begin
               state <= DRAIN;
               cnt   <= '0;
            end else cnt <= cnt + 1;
            DRAIN: if (ofifo_valid) begin
               inst[6]     <= 1'b1;
               inst[32]    <= 1'b0;
               inst[31]    <= 1'b0;
               inst[30:20] <= 11'(P_BASE + kij * LEN_NIJ + cnt);
               cnt         <= cnt + 1;
               if (cnt == LEN_NIJ - 1) begin
                  cnt <= '0;
                  if (kij == KIJ - 1) state <= ACC;
                  else begin
                     kij   <= kij + 1;
                     state <= W_L0;
                  end
               end
            end
            ACC: begin
               // kernel position is the inner loop so relu lands on the last partial sum of each output
               inst[34]    <= k == KIJ - 1;
               inst[33]    <= 1'b1;
               inst[32]    <= 1'b0;
               inst[30:20] <= 11'(P_BASE + k * LEN_NIJ + o);
               k           <= k == KIJ - 1 ? '0 : k + 1;
               if (k == KIJ - 1) begin
                  o <= o + 1;
                  if (o == LEN_ONIJ - 1) begin
                     o     <= '0;
                     state <= FIN;
                     cnt   <= '0;
                  end
               end
            end
            FIN: if (cnt == 1) begin
               state <= IDLE;
               cnt   <= '0;
               busy  <= 1'b0;
               done  <= 1'b1;
            end else cnt <= cnt + 1;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_core_seq.sv
// tb_core_seq: directed checks of core_seq on the default tile and on a reduced single-pass tile.
module tb_core_seq;
   localparam logic [34:0] IDLE_INST = 35'h1_800C_0000;
   logic        clk = 1'b0;
   logic        reset, start_a, start_b, ofv, sel;
   logic [34:0] inst_a, inst_b, inst_m;
   logic        busy_a, busy_b, busy_m, ov_a, ov_b, ov_m, done_a, done_b, done_m;
   int          n_assert = 0;
   int          n_fail = 0;
   logic [10:0] xq[$];
   logic [10:0] pwq[$];
   logic [10:0] prq[$];
   bit          relq[$];
   int n_l0wr, n_load, n_exec, first_xr, first_l0wr, last_load, first_exec, exec_gap;
   int prev_w, wgap_bad, ofrd_bad, acc_bad, ov_err, n_ov, n_done, after;
   bit h1, h2;

   always #5 clk = ~clk;

   core_seq u_a (.clk(clk), .reset(reset), .start(start_a), .ofifo_valid(ofv),
                 .inst(inst_a), .busy(busy_a), .out_valid(ov_a), .done(done_a));
   core_seq #(.KIJ(1), .LEN_NIJ(4), .LEN_ONIJ(2)) u_b (.clk(clk), .reset(reset), .start(start_b),
                 .ofifo_valid(ofv), .inst(inst_b), .busy(busy_b), .out_valid(ov_b), .done(done_b));

   assign inst_m = sel ? inst_b : inst_a;
   assign busy_m = sel ? busy_b : busy_a;
   assign ov_m   = sel ? ov_b : ov_a;
   assign done_m = sel ? done_b : done_a;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_inst"}, inst_m, IDLE_INST);
      chk({tag, "_busy"}, busy_m, 0);
      chk({tag, "_out_valid"}, ov_m, 0);
      chk({tag, "_done"}, done_m, 0);
   endtask

   task automatic run(input bit tog, input bit pulse_exec, input bit stop_pw);
      bit wr;
      xq.delete(); pwq.delete(); prq.delete(); relq.delete();
      n_l0wr = 0; n_load = 0; n_exec = 0; first_xr = -1; first_l0wr = -1; last_load = -1;
      first_exec = -1; exec_gap = -1; prev_w = -1; wgap_bad = 0; ofrd_bad = 0; acc_bad = 0;
      ov_err = 0; n_ov = 0; n_done = 0; after = -1; h1 = 0; h2 = 0;
      for (int c = 0; c < 6000; c++) begin
         @(posedge clk); #1;
         start_a = 0;
         start_b = 0;
         ofv = tog ? ~ofv : 1'b1;
         if (!inst_m[19]) begin
            xq.push_back(inst_m[17:7]);
            if (first_xr < 0) first_xr = c;
         end
         if (inst_m[2]) begin
            n_l0wr++;
            if (first_l0wr < 0) first_l0wr = c;
         end
         if (inst_m[0]) begin
            n_load++;
            last_load = c;
         end
         if (inst_m[1]) begin
            n_exec++;
            if (first_exec < 0) begin
               first_exec = c;
               exec_gap = c - last_load;
               if (pulse_exec) begin
                  if (sel) start_b = 1; else start_a = 1;
               end
            end
         end
         wr = !inst_m[32] && !inst_m[31];
         if (inst_m[6] != wr) ofrd_bad++;
         if (wr) begin
            pwq.push_back(inst_m[30:20]);
            if (prev_w >= 0 && c - prev_w < 10 && c - prev_w != (tog ? 2 : 1)) wgap_bad++;
            prev_w = c;
            if (stop_pw) break;
         end
         if (!inst_m[32] && inst_m[31]) begin
            prq.push_back(inst_m[30:20]);
            relq.push_back(inst_m[34]);
            if (!inst_m[33]) acc_bad++;
         end else if (inst_m[33] || inst_m[34]) acc_bad++;
         if (ov_m !== h2) ov_err++;
         h2 = h1;
         h1 = inst_m[34];
         n_ov += int'(ov_m);
         n_done += int'(done_m);
         if (done_m) after = c;
         if (after >= 0 && c - after >= 4) break;
      end
      chk("run_reached_end", stop_pw ? (pwq.size() > 0) : (after >= 0), 1);
   endtask

   task automatic check_tile(input int kn, input int nij, input int onij, input int gap);
      int bad, idx;
      chk("xmem_reads", xq.size(), kn * (8 + nij));
      bad = 0;
      idx = 0;
      if (xq.size() == kn * (8 + nij)) begin
         for (int kk = 0; kk < kn; kk++) begin
            for (int i = 0; i < 8; i++) if (xq[idx++] !== 11'(kk * 8 + i)) bad++;
            for (int i = 0; i < nij; i++) if (xq[idx++] !== 11'(1024 + i)) bad++;
         end
      end else bad = 1;
      chk("xmem_addr_seq", bad, 0);
      chk("l0wr_lag", first_l0wr - first_xr, 1);
      chk("l0wr_count", n_l0wr, kn * (8 + nij));
      chk("load_count", n_load, kn * 8);
      chk("exec_count", n_exec, kn * nij);
      chk("exec_gap", exec_gap, gap);
      chk("pmem_writes", pwq.size(), kn * nij);
      bad = 0;
      foreach (pwq[j]) if (pwq[j] !== 11'(j)) bad++;
      chk("pmem_wr_addr", bad, 0);
      chk("wr_spacing", wgap_bad, 0);
      chk("ofifo_rd_align", ofrd_bad, 0);
      chk("pmem_reads", prq.size(), kn * onij);
      bad = 0;
      foreach (prq[j]) if (prq[j] !== 11'((j % kn) * nij + j / kn)) bad++;
      chk("acc_addr", bad, 0);
      bad = 0;
      foreach (relq[j]) if (relq[j] !== (j % kn == kn - 1)) bad++;
      chk("relu_pos", bad, 0);
      chk("acc_flag", acc_bad, 0);
      chk("out_valid_count", n_ov, onij);
      chk("out_valid_lag", ov_err, 0);
      chk("done_count", n_done, 1);
      chk("busy_end", busy_m, 0);
   endtask

   initial begin
      reset = 0; start_a = 0; start_b = 0; ofv = 1; sel = 0;
      repeat (3) @(posedge clk);
      #1;
      chk_idle("reset_a");
      sel = 1;
      #1;
      chk_idle("reset_b");
      reset = 1;
      @(posedge clk); #1;
      // reduced tile, ofifo always valid
      start_b = 1;
      run(0, 0, 0);
      check_tile(1, 4, 2, 22);
      // ofifo toggling and a stray start during EXEC
      start_b = 1;
      run(1, 1, 0);
      check_tile(1, 4, 2, 22);
      // restart after done begins again at kij 0
      start_b = 1;
      run(0, 0, 0);
      chk("restart_first_xaddr", xq.size() > 0 ? xq[0] : 11'h7FF, 0);
      chk("restart_done", n_done, 1);
      // default tile interrupted by reset in DRAIN
      sel = 0;
      #1;
      start_a = 1;
      run(0, 0, 1);
      chk("drain_first_addr", pwq.size() > 0 ? pwq[0] : 11'h7FF, 0);
      reset = 0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk_idle("mid_drain_reset");
      end
      reset = 1;
      start_a = 1;
      @(posedge clk); #1;
      start_a = 0;
      chk("start_after_reset", busy_m, 1);
      run(0, 0, 0);
      check_tile(9, 36, 16, 54);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
